// File: rtl/sram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : sram_stream_reader
// Purpose  : Read-side master for a simple dual-port SRAM. Accepts a burst
//            command (base, len), drives the SRAM read port, absorbs the fixed
//            1-cycle read latency and emits the words as a valid/ready stream
//            with a last flag. Issue is credit-gated against a small output
//            FIFO so backpressure is lossless at 1 word/cycle.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            cmd_valid/cmd_ready      - command handshake (ready only in IDLE)
//            cmd_base, cmd_len        - first word address, number of words
//            cmd_stride               - address step (READER_STRIDE_EN only)
//            sram_raddr, sram_rdata   - SRAM read port (rdata 1 cycle later)
//            out_valid/out_ready      - output stream handshake
//            out_data, out_last       - FIFO head word and end-of-burst flag
//            busy                     - high in STREAM or DRAIN
// Options  : `define READER_STRIDE_EN adds cmd_stride; otherwise step is 1.
// Revision : 1.0 - initial release
// ============================================================================
module sram_stream_reader #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 64,
    parameter int LEN_W      = 11,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [LEN_W-1:0]  cmd_len,
`ifdef READER_STRIDE_EN
    input  logic [ADDR_W-1:0] cmd_stride,
`endif
    output logic [ADDR_W-1:0] sram_raddr,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int c_OCC_W = c_CNT_W + 1;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_STREAM = 2'd1;
    localparam logic [1:0] c_ST_DRAIN  = 2'd2;

    logic [1:0]         r_state;
    logic [ADDR_W-1:0]  r_next_addr;
    logic [ADDR_W-1:0]  r_raddr;
    logic [LEN_W-1:0]   r_remaining;
    logic               r_inflight;
    logic               r_inflight_last;

    logic [DATA_W-1:0]  r_fifo_data [FIFO_DEPTH];
    logic               r_fifo_last [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic [ADDR_W-1:0]  w_step;
    logic [c_OCC_W-1:0] w_occ;
    logic               w_pop;
    logic               w_credit;
    logic               w_issue;
    logic               w_head_last;

`ifdef READER_STRIDE_EN
    logic [ADDR_W-1:0]  r_stride;
    assign w_step = r_stride;
`else
    assign w_step = ADDR_W'(1);
`endif

    assign w_pop       = (r_count != '0) && out_ready;
    assign w_head_last = r_fifo_last[r_rd_ptr];

    // Occupancy the FIFO will have after this cycle's pending push/pop. A new
    // read issued now lands one cycle later, so it needs one free slot then.
    assign w_occ    = c_OCC_W'(r_count) + c_OCC_W'(r_inflight) - c_OCC_W'(w_pop);
    assign w_credit = (w_occ <= c_OCC_W'(FIFO_DEPTH - 1));
    assign w_issue  = (r_state == c_ST_STREAM) && w_credit;

    // The address is presented in the issuing cycle itself; otherwise the
    // last issued address is held.
    assign sram_raddr = w_issue ? r_next_addr : r_raddr;

    assign cmd_ready = (r_state == c_ST_IDLE);
    assign busy      = (r_state != c_ST_IDLE);
    assign out_valid = (r_count != '0);
    assign out_data  = r_fifo_data[r_rd_ptr];
    assign out_last  = (r_count != '0) && w_head_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= c_ST_IDLE;
            r_next_addr     <= '0;
            r_raddr         <= '0;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
`ifdef READER_STRIDE_EN
            r_stride        <= '0;
`endif
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_last[i] <= 1'b0;
            end
        end else begin
            // Read pipeline: data for an address issued now is on sram_rdata
            // next cycle and is captured at the end of that cycle.
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_remaining == LEN_W'(1));

            if (r_inflight) begin
                r_fifo_data[r_wr_ptr] <= sram_rdata;
                r_fifo_last[r_wr_ptr] <= r_inflight_last;
                r_wr_ptr              <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({r_inflight, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase

            case (r_state)
                c_ST_IDLE: begin
                    // A zero-length command is consumed without any effect.
                    if (cmd_valid && (cmd_len != '0)) begin
                        r_next_addr <= cmd_base;
                        r_remaining <= cmd_len;
`ifdef READER_STRIDE_EN
                        r_stride    <= cmd_stride;
`endif
                        r_state     <= c_ST_STREAM;
                    end
                end
                c_ST_STREAM: begin
                    if (w_issue) begin
                        r_raddr     <= r_next_addr;
                        r_next_addr <= r_next_addr + w_step;
                        r_remaining <= r_remaining - LEN_W'(1);
                        if (r_remaining == LEN_W'(1)) begin
                            r_state <= c_ST_DRAIN;
                        end
                    end
                end
                c_ST_DRAIN: begin
                    // The tagged word can only be popped after it landed, so
                    // its handshake means nothing remains in flight or queued.
                    if (w_pop && w_head_last) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_stream_reader
// Purpose  : Self-checking bench for sram_stream_reader. A behavioural SRAM
//            holds mem[i] = i, so every expected word equals its address.
//            Burst vectors come from a table; zero-length, reset-mid-burst
//            and reset-state cases are hand-written sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_stream_reader;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 64;
    localparam int LEN_W  = 11;

    logic              clk;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_base;
    logic [LEN_W-1:0]  cmd_len;
`ifdef READER_STRIDE_EN
    logic [ADDR_W-1:0] cmd_stride;
`endif
    logic [ADDR_W-1:0] sram_raddr;
    logic [DATA_W-1:0] sram_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] mem [1024];

    sram_stream_reader #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .LEN_W      (LEN_W),
        .FIFO_DEPTH (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_base   (cmd_base),
        .cmd_len    (cmd_len),
`ifdef READER_STRIDE_EN
        .cmd_stride (cmd_stride),
`endif
        .sram_raddr (sram_raddr),
        .sram_rdata (sram_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM read port with a fixed 1-cycle latency.
    always @(posedge clk) sram_rdata <= mem[sram_raddr];

    typedef struct packed {
        logic [9:0]      base;
        logic [10:0]     len;
        logic [9:0]      stride;
        logic [15:0]     pat;    // out_ready for cycle k is pat[k % 16]
        logic [3:0][9:0] exp;    // expected addresses, exp[0] first
    } vec_t;

    vec_t vecs [8];
    int   nvec;

    function automatic vec_t mk(input logic [9:0] b, input logic [10:0] l,
                                input logic [9:0] s, input logic [15:0] p,
                                input logic [9:0] e0, input logic [9:0] e1,
                                input logic [9:0] e2, input logic [9:0] e3);
        vec_t v;
        v.base = b; v.len = l; v.stride = s; v.pat = p;
        v.exp  = {e3, e2, e1, e0};
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_cmd(input logic [9:0] b, input logic [10:0] l, input logic [9:0] s);
        cmd_valid = 1'b1;
        cmd_base  = b;
        cmd_len   = l;
`ifdef READER_STRIDE_EN
        cmd_stride = s;
`else
        if (s == 10'd0) cmd_base = b;  // stride has no effect without the option
`endif
    endtask

    // Runs one burst; cycle 0 is the command handshake cycle.
    task automatic run_vec(input vec_t v, input int id);
        int          idx;
        int          first_v;
        int          last_hs;
        bit          done;
        logic        pv, pr, pl;
        logic [63:0] pd;
        idx = 0; first_v = -1; last_hs = -1; done = 0;
        pv = 0; pr = 0; pl = 0; pd = '0;
        @(negedge clk);
        drive_cmd(v.base, v.len, v.stride);
        out_ready = v.pat[0];
        #1;
        chk($sformatf("v%0d cmd_ready_at_cmd", id), cmd_ready, 1);
        for (int k = 1; k <= 80 && !done; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            out_ready = v.pat[k % 16];
            #1;
            if (k == 1) begin
                chk($sformatf("v%0d raddr_cycle1", id), sram_raddr, v.base);
                chk($sformatf("v%0d busy_cycle1", id), busy, 1);
                chk($sformatf("v%0d cmd_ready_cycle1", id), cmd_ready, 0);
            end
            if (out_valid && first_v < 0) begin
                first_v = k;
                if (v.pat == 16'hFFFF)
                    chk($sformatf("v%0d first_valid_cycle", id), k, 3);
            end
            if (pv && !pr) begin
                chk($sformatf("v%0d stall_valid", id), out_valid, 1);
                chk($sformatf("v%0d stall_data", id), out_data, pd);
                chk($sformatf("v%0d stall_last", id), out_last, pl);
            end
            if (last_hs >= 0 && k == last_hs + 1) begin
                chk($sformatf("v%0d cmd_ready_after_last", id), cmd_ready, 1);
                chk($sformatf("v%0d no_extra_valid", id), out_valid, 0);
                done = 1;
            end else if (out_valid && out_ready) begin
                if (idx < int'(v.len)) begin
                    chk($sformatf("v%0d data[%0d]", id, idx), out_data, 64'(v.exp[idx]));
                    chk($sformatf("v%0d last[%0d]", id, idx), out_last, (idx == int'(v.len) - 1));
                end else begin
                    chk($sformatf("v%0d extra_word", id), idx, int'(v.len) - 1);
                end
                idx++;
                if (idx == int'(v.len)) last_hs = k;
            end
            pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
        end
        chk($sformatf("v%0d completed", id), done, 1);
    endtask

    task automatic zero_len_seq();
        @(negedge clk);
        drive_cmd(10'd7, 11'd0, 10'd1);
        out_ready = 1'b1;
        #1;
        chk("len0 cmd_ready_at_cmd", cmd_ready, 1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            #1;
            chk($sformatf("len0 cmd_ready c%0d", k), cmd_ready, 1);
            chk($sformatf("len0 busy c%0d", k), busy, 0);
            chk($sformatf("len0 out_valid c%0d", k), out_valid, 0);
        end
    endtask

    task automatic reset_mid_burst_seq();
        int hs;
        hs = 0;
        @(negedge clk);
        drive_cmd(10'd0, 11'd8, 10'd1);
        out_ready = 1'b1;
        for (int k = 1; k <= 40 && hs < 3; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            #1;
            if (out_valid && out_ready) begin
                chk($sformatf("rstseq data[%0d]", hs), out_data, 64'(hs));
                hs++;
            end
        end
        chk("rstseq three_words_seen", hs, 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstseq out_valid", out_valid, 0);
        chk("rstseq cmd_ready", cmd_ready, 1);
        chk("rstseq busy", busy, 0);
        chk("rstseq out_last", out_last, 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 64'(i);
        rst = 1'b1; cmd_valid = 1'b0; cmd_base = '0; cmd_len = '0; out_ready = 1'b0;
`ifdef READER_STRIDE_EN
        cmd_stride = '0;
`endif
        nvec = 0;
        vecs[nvec++] = mk(10'd5,    11'd4, 10'd1, 16'hFFFF, 10'd5,    10'd6,    10'd7, 10'd8);
        vecs[nvec++] = mk(10'd5,    11'd4, 10'd1, 16'hAAA9, 10'd5,    10'd6,    10'd7, 10'd8);
        vecs[nvec++] = mk(10'd1022, 11'd4, 10'd1, 16'hFFFF, 10'd1022, 10'd1023, 10'd0, 10'd1);
        vecs[nvec++] = mk(10'd1023, 11'd3, 10'd1, 16'h3333, 10'd1023, 10'd0,    10'd1, 10'd0);
        vecs[nvec++] = mk(10'd9,    11'd1, 10'd1, 16'hFFFF, 10'd9,    10'd0,    10'd0, 10'd0);
        vecs[nvec++] = mk(10'd0,    11'd2, 10'd1, 16'hFFFF, 10'd0,    10'd1,    10'd0, 10'd0);
`ifdef READER_STRIDE_EN
        vecs[nvec++] = mk(10'd0,    11'd3, 10'd4, 16'hFFFF, 10'd0,    10'd4,    10'd8, 10'd0);
        vecs[nvec++] = mk(10'd0,    11'd2, 10'd0, 16'hFFFF, 10'd0,    10'd0,    10'd0, 10'd0);
`endif

        repeat (3) @(negedge clk);
        #1;
        chk("reset cmd_ready", cmd_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset sram_raddr", sram_raddr, 0);
        chk("reset out_data", out_data, 0);
        chk("reset out_last", out_last, 0);
        rst = 1'b0;

        for (int i = 0; i < nvec; i++) begin
            if (i == 4) zero_len_seq();
            if (i == 5) reset_mid_burst_seq();
            run_vec(vecs[i], i);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
